// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads instruction memory, and
// presents each fetched instruction to decode over a valid/ready handshake.
module fetch_unit #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic                  redirectValid,
  input  logic [31:0]           redirectTarget,
  input  logic                  outReady,
  output logic                  outValid,
  output logic [DATA_WIDTH-1:0] outInstruction,
  output logic [31:0]           outPc,
  output logic                  halted,
  output logic [1:0]            errorCode,
  output logic [31:0]           fetchCount
);

  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);

  typedef enum logic {RUN, HALT} state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_MISALIGN  = 2'd1,
    ERR_OUT_RANGE = 2'd2
  } err_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [31:0]           out_pc_q, out_pc_d;
  err_e                  error_q, error_d;
  logic [31:0]           fetch_count_q, fetch_count_d;

  logic slot_free;
  logic pc_out_of_range;

  assign slot_free       = !out_valid_q || outReady;
  // Any address bit above the memory's word index means the PC left the array.
  assign pc_out_of_range = |pc_q[31:ADDR_WIDTH+2];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    error_d       = error_q;
    fetch_count_d = fetch_count_q;

    if (out_valid_q && outReady && !redirectValid)
      fetch_count_d = fetch_count_q + 32'd1;

    unique case (state_q)
      RUN: begin
        if (redirectValid) begin
          out_valid_d = 1'b0;
          pc_d        = redirectTarget;
          if (redirectTarget[1:0] != 2'b00) begin
            state_d = HALT;
            error_d = ERR_MISALIGN;
          end
        end else if (slot_free) begin
          if (pc_out_of_range) begin
            state_d     = HALT;
            error_d     = ERR_OUT_RANGE;
            out_valid_d = 1'b0;
          end else begin
            out_instr_d = instruction;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            // The EBREAK itself is still handed to decode.
            if (instruction == EBREAK)
              state_d = HALT;
          end
        end
      end
      HALT: begin
        if (out_valid_q && outReady)
          out_valid_d = 1'b0;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      error_q       <= ERR_NONE;
      fetch_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      error_q       <= error_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign readAddress    = pc_q[ADDR_WIDTH+1:2];
  assign outValid       = out_valid_q;
  assign outInstruction = out_instr_q;
  assign outPc          = out_pc_q;
  assign halted         = (state_q == HALT);
  assign errorCode      = error_q;
  assign fetchCount     = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_fetch_unit;

  localparam int          AW        = 5;
  localparam int          DEPTH     = 1 << AW;
  localparam int unsigned MEM_BYTES = 4 * DEPTH;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic [AW-1:0] readAddress;
  logic [31:0] instruction;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        outReady;
  logic        outValid;
  logic [31:0] outInstruction;
  logic [31:0] outPc;
  logic        halted;
  logic [1:0]  errorCode;
  logic [31:0] fetchCount;

  logic [31:0] mem [DEPTH];

  always #5 clk = ~clk;

  assign instruction = mem[readAddress];

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .readAddress(readAddress), .instruction(instruction),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget), .outReady(outReady),
    .outValid(outValid), .outInstruction(outInstruction), .outPc(outPc),
    .halted(halted), .errorCode(errorCode), .fetchCount(fetchCount)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model state: what decode should see, not how the RTL stores it.
  int unsigned m_pc;
  bit          m_halted;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  int unsigned m_err;
  int unsigned m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit rv, input logic [31:0] rt, input bit rdy);
    if (rst) begin
      m_pc = 0; m_halted = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_err = 0; m_count = 0;
      return;
    end
    if (m_valid && rdy && !rv) m_count++;
    if (m_halted) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (rv) begin
      m_valid = 0;
      m_pc    = rt;
      if (rt % 4 != 0) begin m_halted = 1; m_err = 1; end
    end else if (!m_valid || rdy) begin
      if (m_pc >= MEM_BYTES) begin
        m_halted = 1; m_err = 2; m_valid = 0;
      end else begin
        m_instr = mem[m_pc / 4];
        m_opc   = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 4;
        if (m_instr == EBREAK) m_halted = 1;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare #1 later.
  task automatic cycle(input bit rst, input bit rv, input logic [31:0] rt, input bit rdy);
    reset = rst; redirectValid = rv; redirectTarget = rt; outReady = rdy;
    @(posedge clk);
    model_edge(rst, rv, rt, rdy);
    #1;
    check("outValid",       {31'b0, outValid},  {31'b0, m_valid});
    check("outPc",          outPc,              m_opc);
    check("outInstruction", outInstruction,     m_instr);
    check("halted",         {31'b0, halted},    {31'b0, m_halted});
    check("errorCode",      {30'b0, errorCode}, m_err);
    check("fetchCount",     fetchCount,         m_count);
    check("readAddress",    {27'b0, readAddress}, (m_pc >> 2) % DEPTH);
  endtask

  task automatic load_linear_mem(input bit with_ebreak);
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    if (with_ebreak) mem[5] = EBREAK;
  endtask

  initial begin
    reset = 1'b1; redirectValid = 1'b0; redirectTarget = '0; outReady = 1'b1;

    // Sequential fetch, stall, redirect during stall, misaligned redirect.
    load_linear_mem(1'b0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("rst_outValid", {31'b0, outValid}, 32'd0);
    check("rst_count", fetchCount, 32'd0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1);
    check("seq_pc8", outPc, 32'h8);
    check("seq_count", fetchCount, 32'd2);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0);
      check("stall_instr", outInstruction, 32'h1000_0002);
      check("stall_ra", {27'b0, readAddress}, 32'd3);
      check("stall_count", fetchCount, 32'd2);
    end
    cycle(0, 0, 0, 1);
    check("post_stall_pc", outPc, 32'hC);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h40, 0);
    check("redir_bubble", {31'b0, outValid}, 32'd0);
    cycle(0, 0, 0, 1);
    check("redir_pc", outPc, 32'h40);
    check("redir_instr", outInstruction, 32'h1000_0010);
    cycle(0, 1, 32'h42, 1);
    check("misalign_halt", {31'b0, halted}, 32'd1);
    check("misalign_err", {30'b0, errorCode}, 32'd1);
    check("misalign_valid", {31'b0, outValid}, 32'd0);

    // EBREAK halt; redirects ignored afterwards.
    load_linear_mem(1'b1);
    cycle(1, 0, 0, 1);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 1);
    check("ebreak_pc", outPc, 32'h14);
    check("ebreak_instr", outInstruction, EBREAK);
    check("ebreak_halt", {31'b0, halted}, 32'd1);
    for (int k = 0; k < 4; k++) cycle(0, k[0], 32'h20, 1);
    check("ebreak_no_valid", {31'b0, outValid}, 32'd0);
    check("ebreak_err", {30'b0, errorCode}, 32'd0);

    // Out-of-range: run off the end of memory.
    load_linear_mem(1'b0);
    cycle(1, 0, 0, 1);
    for (int k = 0; k < 32; k++) cycle(0, 0, 0, 1);
    check("range_last_pc", outPc, 32'h7C);
    cycle(0, 0, 0, 1);
    check("range_halt", {31'b0, halted}, 32'd1);
    check("range_err", {30'b0, errorCode}, 32'd2);
    check("range_valid", {31'b0, outValid}, 32'd0);

    // Reset while halted with an undelivered EBREAK held.
    load_linear_mem(1'b1);
    cycle(1, 0, 0, 1);
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check("held_valid", {31'b0, outValid}, 32'd1);
    cycle(1, 0, 0, 0);
    check("rst_halt_valid", {31'b0, outValid}, 32'd0);
    check("rst_halt_halted", {31'b0, halted}, 32'd0);
    check("rst_halt_pc", outPc, 32'h0);
    check("rst_halt_instr", outInstruction, 32'h0);
    cycle(0, 0, 0, 1);
    check("restart_pc", outPc, 32'h0);
    check("restart_valid", {31'b0, outValid}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < DEPTH; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
    cycle(1, 0, 0, 1);
    for (int n = 0; n < 1500; n++) begin
      bit          rst, rv, rdy;
      logic [31:0] rt;
      int unsigned kind;
      rst  = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 4) == 0);
      rv   = ($urandom_range(0, 99) < 8);
      rdy  = ($urandom_range(0, 99) < 70);
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1:    rt = 32'($urandom_range(0, DEPTH - 1)) * 4;
        2:       rt = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        default: rt = $urandom;
      endcase
      cycle(rst, rv, rt, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the single-cycle RISC-V core, sitting directly upstream of `instructionMemory`. It owns the program counter, drives the memory's word `readAddress`, captures the returned `instruction` into an output register, and hands it to decode over a valid/ready handshake. It also handles control-flow redirects, EBREAK halt and fetch-error detection.

## Interface
- `ADDR_WIDTH`, 5: word-address width of instruction memory; memory holds 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `readAddress`  out  ADDR_WIDTH  word address to instruction memory; always equals `pc[ADDR_WIDTH+1:2]`.
- `instruction`  in  DATA_WIDTH  combinational read data from instruction memory.
- `redirectValid`  in  1  branch/jump redirect request.
- `redirectTarget`  in  32  redirect byte address.
- `outReady`  in  1  decode can accept.
- `outValid`  out  1  `outInstruction`/`outPc` valid.
- `outInstruction`  out  DATA_WIDTH  fetched instruction.
- `outPc`  out  32  byte address of `outInstruction`.
- `halted`  out  1  fetch stopped; only `reset` clears it.
- `errorCode`  out  2  0 = none, 1 = misaligned redirect, 2 = PC out of memory range.
- `fetchCount`  out  32  number of instructions accepted by decode.

## Operation
- Internal 32-bit `pc`. FSM states: RUN and HALT. `halted` = (state == HALT).
- Reset (`reset` high at an edge) sets `pc` = RESET_PC, state = RUN, `outValid` = 0, `outInstruction` = 0, `outPc` = 0, `errorCode` = 0, `fetchCount` = 0. Reset overrides all other inputs.
- `slotFree` = !outValid || outReady.
- Priority in RUN, highest first:
  - Redirect: `redirectValid` high causes `outValid` <= 0 (held or just-fetched instruction is flushed) and `pc` <= redirectTarget. If redirectTarget[1:0] != 0, state <= HALT and `errorCode` <= 1. Redirect wins over stall, EBREAK and out-of-range.
  - Load (`slotFree`, no redirect): if `pc[31:ADDR_WIDTH+2]` != 0, state <= HALT, `errorCode` <= 2, `outValid` <= 0. Otherwise `outInstruction` <= instruction, `outPc` <= pc, `outValid` <= 1, `pc` <= pc + 4. If instruction == 32'h0010_0073 (EBREAK), state <= HALT; the EBREAK itself is still delivered.
  - Stall (`outValid` && !outReady): outputs and `pc` hold; `readAddress` is unchanged.
- HALT: no further fetch; `redirectValid` is ignored; `pc` frozen. A pending `outValid` is held until `outReady`, then cleared.
- `fetchCount` increments on each edge with `outValid && outReady && !redirectValid` (all states). It wraps modulo 2^32.
- PC arithmetic is 32-bit modulo; the out-of-range check stops fetching before any wrap reaches memory.

## Timing
- Fetch latency is 1 cycle: the instruction at `pc` is registered on the edge where it loads. With `outReady` held high, throughput is 1 instruction per cycle.
- First `outValid` appears 1 cycle after the first edge with `reset` low, carrying mem[RESET_PC>>2].
- Redirect costs 1 bubble: the edge with `redirectValid` high clears `outValid`; the next edge presents the target instruction.
- `halted` and `errorCode` update on the same edge as the triggering condition.
- Reset asserted mid-stall or in HALT discards everything and restarts at RESET_PC.

## Test plan
- Memory word i = 32'h1000_0000+i, RESET_PC=0, outReady=1: after reset, outPc = 0x0, 0x4, 0x8… on consecutive cycles; outInstruction = 0x1000_0000, 0x1000_0001…; fetchCount increments each cycle.
- outReady low for 3 cycles while outPc=0x8: outInstruction holds 0x1000_0002 and readAddress holds 3; after outReady is released, next outPc = 0xC with no drop or duplicate; fetchCount is unchanged during the stall.
- redirectTarget=0x40 asserted for 1 cycle during stall: outValid = 0 for one cycle, then outPc=0x40 and outInstruction=0x1000_0010. A second redirect to 0x42 gives halted=1, errorCode=1, outValid=0.
- Word 5 = 32'h0010_0073: outPc=0x14 is delivered with the EBREAK, then halted=1 and errorCode=0. No further outValid follows, even with redirectValid pulsed.
- Run sequentially from 0: the last delivered outPc = 0x7C; the next cycle gives halted=1, errorCode=2, outValid=0.
- Assert reset while halted with outValid held and outReady=0: the next cycle shows all outputs at reset values; fetch restarts at outPc=0x0.
